// File: rtl/console_pkg.sv
// Shared constants and FSM encoding for the sys_console host sequencer.
package console_pkg;

   localparam logic [7:0] ADDR_STAT = 8'h00;
   localparam logic [7:0] ADDR_DATA = 8'h01;
   localparam logic [7:0] ADDR_CONN = 8'h06;
   localparam logic [7:0] CMD_HB    = 8'hdd;
   localparam int         STAT_AVAIL = 0;

   typedef enum logic [2:0] {
      IDLE,
      WR_CONN,
      POLL_RD,
      POLL_CAP,
      DATA_RD,
      DATA_CAP,
      DATA_OUT
   } state_t;

endpackage

// File: rtl/console_tick.sv
// Saturating interval timer: down-counter reloaded on clear, done at terminal count.
module console_tick #(
   parameter int CNT_W = 16,
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(LIMIT);

   logic [CNT_W-1:0] remain;

   // Stops at zero, so done stays high until the owner clears it.
   always_ff @(posedge clk) begin
      if (reset || clear)
         remain <= LOAD;
      else if (enable && (remain != '0))
         remain <= remain - CNT_W'(1);
   end

   assign done = (remain == '0);

endmodule

// File: rtl/console_seq.sv
// Host-side sequencer multiplexing commands, heartbeats and RSTAT/RDATA
// draining onto the single sys_console register port.
//
// state    | meaning
// IDLE     | arbitrate: command > pending heartbeat > due poll
// WR_CONN  | one-cycle write of latched byte to CONN
// POLL_RD  | read strobe to RSTAT
// POLL_CAP | sample status, start burst if data available
// DATA_RD  | read strobe to RDATA
// DATA_CAP | latch RDATA byte
// DATA_OUT | present byte on rx stream until accepted
module console_seq
   import console_pkg::*;
#(
   parameter int POLL_INTERVAL = 16,
   parameter int HB_INTERVAL   = 1000,
   parameter int MAX_BURST     = 198,
   parameter int CNT_W         = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_data,
   input  logic       hb_enable,
   output logic [7:0] slave_address,
   output logic       slave_read,
   input  logic [7:0] slave_readdata,
   output logic       slave_write,
   output logic [7:0] slave_writedata,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       busy
);

   state_t           state, state_nx;
   logic [7:0]       wr_byte;
   logic             wr_is_hb;
   logic [7:0]       rx_byte;
   logic [CNT_W-1:0] burst_cnt;
   logic [CNT_W-1:0] burst_nx;
   logic             burst_more;
   logic             hb_pend;
   logic             hb_due;
   logic             poll_due;
   logic             cmd_take;
   logic             hb_take;
   logic             poll_start;
   logic             burst_go;

   console_tick #(.CNT_W(CNT_W), .LIMIT(POLL_INTERVAL)) u_poll_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (poll_start),
      .enable (state == IDLE),
      .done   (poll_due)
   );

   // Any CONN write, command or heartbeat, restarts the heartbeat interval.
   console_tick #(.CNT_W(CNT_W), .LIMIT(HB_INTERVAL - 1)) u_hb_tick (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == WR_CONN),
      .enable (1'b1),
      .done   (hb_due)
   );

   assign burst_nx   = burst_cnt + CNT_W'(1);
   assign burst_more = (burst_nx < CNT_W'(MAX_BURST));

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx        = state;
      cmd_take        = 1'b0;
      hb_take         = 1'b0;
      poll_start      = 1'b0;
      burst_go        = 1'b0;
      slave_address   = 8'h00;
      slave_read      = 1'b0;
      slave_write     = 1'b0;
      slave_writedata = 8'h00;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               cmd_take = 1'b1;
               state_nx = WR_CONN;
            end else if (hb_pend) begin
               hb_take  = 1'b1;
               state_nx = WR_CONN;
            end else if (poll_due) begin
               poll_start = 1'b1;
               state_nx   = POLL_RD;
            end
         end
         WR_CONN: begin
            slave_write     = 1'b1;
            slave_address   = ADDR_CONN;
            slave_writedata = wr_byte;
            state_nx        = IDLE;
         end
         POLL_RD: begin
            slave_read    = 1'b1;
            slave_address = ADDR_STAT;
            state_nx      = POLL_CAP;
         end
         POLL_CAP: begin
            if (slave_readdata[STAT_AVAIL]) begin
               burst_go = 1'b1;
               state_nx = DATA_RD;
            end else begin
               state_nx = IDLE;
            end
         end
         DATA_RD: begin
            slave_read    = 1'b1;
            slave_address = ADDR_DATA;
            state_nx      = DATA_CAP;
         end
         DATA_CAP: state_nx = DATA_OUT;
         DATA_OUT: begin
            if (rx_ready)
               state_nx = burst_more ? DATA_RD : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_byte   <= 8'h00;
         wr_is_hb  <= 1'b0;
         rx_byte   <= 8'h00;
         burst_cnt <= '0;
         hb_pend   <= 1'b0;
      end else begin
         if (cmd_take) begin
            wr_byte  <= cmd_data;
            wr_is_hb <= 1'b0;
         end else if (hb_take) begin
            wr_byte  <= CMD_HB;
            wr_is_hb <= 1'b1;
         end
         if (burst_go)
            burst_cnt <= '0;
         else if ((state == DATA_OUT) && rx_ready)
            burst_cnt <= burst_nx;
         if (state == DATA_CAP)
            rx_byte <= slave_readdata;
         // Clear must win: the timer is still saturated during the heartbeat write.
         if (((state == WR_CONN) && wr_is_hb) || !hb_enable)
            hb_pend <= 1'b0;
         else if (hb_due)
            hb_pend <= 1'b1;
      end
   end

   assign cmd_ready = (state == IDLE) && !reset;
   assign rx_valid  = (state == DATA_OUT);
   assign rx_data   = rx_byte;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_console_seq.sv
// Self-checking bench for console_seq: vector table for the command path,
// directed sequences for polling, bursts, heartbeats and reset.
module tb_console_seq;

   // Long poll interval keeps polls out of the heartbeat spacing windows.
   localparam int PI  = 200;
   localparam int HBI = 50;
   localparam int MB  = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [7:0] cmd_data = 8'h00;
   logic       hb_enable = 1'b0;
   logic [7:0] slave_address;
   logic       slave_read;
   logic [7:0] slave_readdata;
   logic       slave_write;
   logic [7:0] slave_writedata;
   logic       rx_valid;
   logic       rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       busy;

   always #5 clk = ~clk;

   console_seq #(
      .POLL_INTERVAL (PI),
      .HB_INTERVAL   (HBI),
      .MAX_BURST     (MB),
      .CNT_W         (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_data        (cmd_data),
      .hb_enable       (hb_enable),
      .slave_address   (slave_address),
      .slave_read      (slave_read),
      .slave_readdata  (slave_readdata),
      .slave_write     (slave_write),
      .slave_writedata (slave_writedata),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .busy            (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: status returns 0x01 once per arm request, data counts from 0x10.
   int         arm_req = 0;
   int         arm_ack = 0;
   int         data_ptr = 0;
   logic [7:0] readdata = 8'h00;
   assign slave_readdata = readdata;

   always @(posedge clk) begin
      if (slave_read) begin
         if (slave_address == 8'h00) begin
            readdata <= (arm_req != arm_ack) ? 8'h01 : 8'h00;
            arm_ack  <= arm_req;
         end else begin
            readdata <= 8'h10 + 8'(data_ptr);
            data_ptr <= data_ptr + 1;
         end
      end
   end

   // Bus monitor: logs strobes and counts protocol violations.
   int         poll_q[$];
   int         data_q[$];
   int         wr_cyc_q[$];
   logic [7:0] wr_dat_q[$];
   int         proto_err = 0;
   logic       prev_rd = 1'b0;
   logic       prev_wr = 1'b0;

   always @(negedge clk) begin
      if (slave_read && slave_write) proto_err++;
      if (prev_rd && slave_read) proto_err++;
      if (prev_wr && slave_write) proto_err++;
      if (!slave_read && !slave_write && slave_address != 8'h00) proto_err++;
      if (!slave_write && slave_writedata != 8'h00) proto_err++;
      if (slave_read) begin
         if (slave_address == 8'h00) poll_q.push_back(cyc);
         else if (slave_address == 8'h01) data_q.push_back(cyc);
         else proto_err++;
      end
      if (slave_write) begin
         if (slave_address != 8'h06) proto_err++;
         wr_cyc_q.push_back(cyc);
         wr_dat_q.push_back(slave_writedata);
      end
      prev_rd = slave_read;
      prev_wr = slave_write;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset(output int n0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      n0 = cyc;
   endtask

   task automatic wait_rx(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rx_valid) break;
      end
   endtask

   task automatic wait_polls(input int need, input int budget);
      for (int i = 0; i < budget && poll_q.size() < need; i++) @(negedge clk);
   endtask

   task automatic wait_writes(input int need, input int budget);
      for (int i = 0; i < budget && wr_cyc_q.size() < need; i++) @(negedge clk);
   endtask

   // {cmd_ready, slave_write, slave_address, slave_writedata, slave_read, busy}
   function automatic logic [19:0] ex(input logic rdy, input logic wr, input logic [7:0] a,
                                      input logic [7:0] wd, input logic rd, input logic bsy);
      return {rdy, wr, a, wd, rd, bsy};
   endfunction

   typedef struct {
      logic        rst;
      logic        cv;
      logic [7:0]  cd;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int n0, pb, db, wb, t0, t1, t2, t3, bad;

      vecs[0]  = '{1'b1, 1'b0, 8'h00, ex(0, 0, 8'h00, 8'h00, 0, 0)};
      vecs[1]  = '{1'b1, 1'b1, 8'hbb, ex(0, 0, 8'h00, 8'h00, 0, 0)};
      vecs[2]  = '{1'b0, 1'b1, 8'hbb, ex(1, 0, 8'h00, 8'h00, 0, 0)};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, ex(0, 1, 8'h06, 8'hbb, 0, 1)};
      vecs[4]  = '{1'b0, 1'b1, 8'h3c, ex(1, 0, 8'h00, 8'h00, 0, 0)};
      vecs[5]  = '{1'b0, 1'b1, 8'hc3, ex(0, 1, 8'h06, 8'h3c, 0, 1)};
      vecs[6]  = '{1'b0, 1'b1, 8'hc3, ex(1, 0, 8'h00, 8'h00, 0, 0)};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, ex(0, 1, 8'h06, 8'hc3, 0, 1)};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, ex(1, 0, 8'h00, 8'h00, 0, 0)};
      vecs[9]  = '{1'b1, 1'b1, 8'h77, ex(0, 0, 8'h00, 8'h00, 0, 0)};
      vecs[10] = '{1'b0, 1'b0, 8'h00, ex(1, 0, 8'h00, 8'h00, 0, 0)};
      vecs[11] = '{1'b0, 1'b0, 8'h00, ex(1, 0, 8'h00, 8'h00, 0, 0)};

      repeat (3) @(posedge clk);

      // Command path, cycle by cycle
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         cmd_valid = vecs[i].cv;
         cmd_data  = vecs[i].cd;
         #1;
         check($sformatf("vec%0d", i),
               {12'h000, cmd_ready, slave_write, slave_address, slave_writedata, slave_read, busy},
               {12'h000, vecs[i].exp});
      end
      cmd_valid = 1'b0;

      // Empty status: no data reads, polls PI+3 apart, first one PI after release
      do_reset(n0);
      pb = poll_q.size();
      db = data_q.size();
      wait_polls(pb + 3, 3 * PI + 50);
      check("polls_seen", poll_q.size() - pb, 3);
      if (poll_q.size() >= pb + 3) begin
         check("first_poll_after_reset", poll_q[pb] - n0, PI + 1);
         check("poll_gap_1", poll_q[pb+1] - poll_q[pb], PI + 3);
         check("poll_gap_2", poll_q[pb+2] - poll_q[pb+1], PI + 3);
      end
      check("no_data_reads", data_q.size() - db, 0);

      // Burst of MB bytes with a 10-cycle stall on the second byte
      @(posedge clk); #1;
      pb = poll_q.size();
      db = data_q.size();
      rx_ready = 1'b1;
      arm_req++;
      wait_rx(PI + 50);
      check("rx_byte0", rx_data, 8'h10);
      t0 = cyc;
      wait_rx(20);
      check("rx_byte1", rx_data, 8'h11);
      t1 = cyc;
      check("rx_gap01", t1 - t0, 3);
      rx_ready = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!rx_valid || rx_data != 8'h11 || slave_read) bad++;
      end
      check("stall_hold", bad, 0);
      check("stall_no_reads", data_q.size() - db, 2);
      rx_ready = 1'b1;
      wait_rx(20);
      check("rx_byte2", rx_data, 8'h12);
      t2 = cyc;
      wait_rx(20);
      check("rx_byte3", rx_data, 8'h13);
      t3 = cyc;
      check("rx_gap23", t3 - t2, 3);
      @(negedge clk);
      check("burst_end_idle", {busy, rx_valid}, 2'b00);
      check("burst_reads", data_q.size() - db, MB);
      if (poll_q.size() > pb && data_q.size() > db)
         check("poll_to_data", data_q[db] - poll_q[poll_q.size()-1], 2);

      // Heartbeat every HBI+2 cycles with no other traffic
      do_reset(n0);
      hb_enable = 1'b1;
      wb = wr_cyc_q.size();
      wait_writes(wb + 3, 3 * HBI + 50);
      check("hb_writes_seen", wr_cyc_q.size() - wb, 3);
      if (wr_cyc_q.size() >= wb + 3) begin
         check("hb_first", wr_cyc_q[wb] - n0, HBI + 1);
         check("hb_gap_1", wr_cyc_q[wb+1] - wr_cyc_q[wb], HBI + 2);
         check("hb_gap_2", wr_cyc_q[wb+2] - wr_cyc_q[wb+1], HBI + 2);
         check("hb_data", {wr_dat_q[wb], wr_dat_q[wb+1], wr_dat_q[wb+2]}, 24'hdddddd);
      end

      // Command on the cycle the heartbeat becomes pending
      do_reset(n0);
      hb_enable = 1'b1;
      wb = wr_cyc_q.size();
      repeat (HBI) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data  = 8'h5a;
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_writes(wb + 2, 20);
      check("collide_writes_seen", wr_cyc_q.size() - wb, 2);
      if (wr_cyc_q.size() >= wb + 2) begin
         check("collide_cmd_first", {wr_cyc_q[wb] - n0, wr_dat_q[wb]}, {32'(HBI + 1), 8'h5a});
         check("collide_hb_next", {wr_cyc_q[wb+1] - wr_cyc_q[wb], wr_dat_q[wb+1]}, {32'd2, 8'hdd});
      end
      hb_enable = 1'b0;

      // Reset in the middle of a stalled burst with a heartbeat pending
      @(posedge clk); #1;
      rx_ready = 1'b0;
      arm_req++;
      wait_rx(PI + 50);
      check("burst2_started", rx_valid, 1'b1);
      wb = wr_cyc_q.size();
      hb_enable = 1'b1;
      repeat (HBI + 10) @(negedge clk);
      check("hb_stalled_in_burst", wr_cyc_q.size() - wb, 0);
      check("rx_still_held", rx_valid, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_outputs_zero",
            {cmd_ready, slave_address, slave_read, slave_write, slave_writedata,
             rx_valid, rx_data, busy}, 32'h0);
      reset = 1'b0;
      n0 = cyc;
      wb = wr_cyc_q.size();
      pb = poll_q.size();
      repeat (10) @(negedge clk);
      check("no_hb_after_reset", wr_cyc_q.size() - wb, 0);
      hb_enable = 1'b0;
      rx_ready  = 1'b1;
      wait_polls(pb + 1, PI + 50);
      check("mid_reset_poll_seen", poll_q.size() - pb, 1);
      if (poll_q.size() > pb)
         check("mid_reset_first_poll", poll_q[pb] - n0, PI + 1);

      check("bus_protocol", proto_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
